// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC and streams instruction words from a 1-cycle-latency memory to decode
module fetch_sequencer #(
    parameter int ADDR_WIDTH  = 4,
    parameter int INSTR_WIDTH = 16,
    parameter int LAST_ADDR   = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [ADDR_WIDTH-1:0]  i_start_pc,
    output logic [ADDR_WIDTH-1:0]  o_imem_address,
    input  logic [INSTR_WIDTH-1:0] i_imem_data,
    output logic [INSTR_WIDTH-1:0] o_instr_out,
    output logic [ADDR_WIDTH-1:0]  o_instr_pc,
    output logic                   o_instr_valid,
    input  logic                   i_instr_ready,
    input  logic                   i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  i_redirect_target,
    output logic                   o_halted,
    output logic                   o_busy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_HOLD,
        S_HALT
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_pc, w_pc_nxt;
    logic [ADDR_WIDTH-1:0]  r_imem_address, w_imem_address_nxt;
    logic [ADDR_WIDTH-1:0]  r_instr_pc, w_instr_pc_nxt;
    logic [INSTR_WIDTH-1:0] r_instr_out, w_instr_out_nxt;
    logic                   r_instr_valid, w_instr_valid_nxt;
    logic                   r_halted, w_halted_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   w_enter;
    logic [ADDR_WIDTH-1:0]  w_enter_addr;

    // Next-state logic; every path that restarts a fetch funnels through w_enter so the range check lives in one place
    always_comb begin
        w_state_nxt        = r_state;
        w_pc_nxt           = r_pc;
        w_imem_address_nxt = r_imem_address;
        w_instr_pc_nxt     = r_instr_pc;
        w_instr_out_nxt    = r_instr_out;
        w_instr_valid_nxt  = r_instr_valid;
        w_halted_nxt       = r_halted;
        w_enter            = 1'b0;
        w_enter_addr       = r_pc;
        case (r_state)
            S_IDLE: begin
                w_enter      = i_start;
                w_enter_addr = i_start_pc;
            end
            S_ISSUE: begin
                if (i_redirect_valid) begin
                    w_instr_valid_nxt = 1'b0;
                    w_enter           = 1'b1;
                    w_enter_addr      = i_redirect_target;
                end else begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (i_redirect_valid) begin
                    w_instr_valid_nxt = 1'b0;
                    w_enter           = 1'b1;
                    w_enter_addr      = i_redirect_target;
                end else begin
                    w_instr_out_nxt   = i_imem_data;
                    w_instr_pc_nxt    = r_pc;
                    w_instr_valid_nxt = 1'b1;
                    w_pc_nxt          = r_pc + ADDR_WIDTH'(1);
                    w_state_nxt       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_redirect_valid || i_instr_ready) begin
                    w_instr_valid_nxt = 1'b0;
                    w_enter           = 1'b1;
                    w_enter_addr      = i_redirect_valid ? i_redirect_target : r_pc;
                end
            end
            S_HALT: begin
                w_instr_valid_nxt = 1'b0;
                if (i_start) begin
                    w_halted_nxt = 1'b0;
                    w_enter      = 1'b1;
                    w_enter_addr = i_start_pc;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_enter) begin
            if (int'(w_enter_addr) > LAST_ADDR) begin
                w_state_nxt  = S_HALT;
                w_halted_nxt = 1'b1;
            end else begin
                w_imem_address_nxt = w_enter_addr;
                w_pc_nxt           = w_enter_addr;
                w_state_nxt        = S_ISSUE;
            end
        end
        w_busy_nxt = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_CAPTURE) || (w_state_nxt == S_HOLD);
    end

    // State and output registers; busy is registered from the next state so no output is combinational
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_pc           <= '0;
            r_imem_address <= '0;
            r_instr_pc     <= '0;
            r_instr_out    <= '0;
            r_instr_valid  <= 1'b0;
            r_halted       <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_pc           <= w_pc_nxt;
            r_imem_address <= w_imem_address_nxt;
            r_instr_pc     <= w_instr_pc_nxt;
            r_instr_out    <= w_instr_out_nxt;
            r_instr_valid  <= w_instr_valid_nxt;
            r_halted       <= w_halted_nxt;
            r_busy         <= w_busy_nxt;
        end
    end

    assign o_imem_address = r_imem_address;
    assign o_instr_out    = r_instr_out;
    assign o_instr_pc     = r_instr_pc;
    assign o_instr_valid  = r_instr_valid;
    assign o_halted       = r_halted;
    assign o_busy         = r_busy;
endmodule
